// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, asserts the start bit, then shifts
// one byte plus odd parity out on device clock falling edges and checks the device ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int unsigned InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } state_e;

    state_e            state_q, state_d;
    logic [1:0]        clk_sync_q, clk_sync_d;
    logic [1:0]        dat_sync_q, dat_sync_d;
    logic              clk_prev_q, clk_prev_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              parity_q, parity_d;
    logic [3:0]        bitcnt_q, bitcnt_d;
    logic [InhW-1:0]   inh_cnt_q, inh_cnt_d;
    logic [ToW-1:0]    to_cnt_q, to_cnt_d;
    logic              ack_flag_q, ack_flag_d;
    logic              clk_oe_q, clk_oe_d;
    logic              dat_oe_q, dat_oe_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ack_err_q, ack_err_d;
    logic              timeout_q, timeout_d;

    logic              clk_s;
    logic              dat_s;
    logic              fe;
    logic              in_xfer;

    assign clk_s   = clk_sync_q[1];
    assign dat_s   = dat_sync_q[1];
    assign fe      = clk_prev_q & ~clk_s;
    assign in_xfer = (state_q == StReq) || (state_q == StData) || (state_q == StParity) ||
                     (state_q == StStop) || (state_q == StWaitIdle);

    always_comb begin
        state_d    = state_q;
        clk_sync_d = {clk_sync_q[0], ps2_clk_in};
        dat_sync_d = {dat_sync_q[0], ps2_dat_in};
        clk_prev_d = clk_s;
        shreg_d    = shreg_q;
        parity_d   = parity_q;
        bitcnt_d   = bitcnt_q;
        inh_cnt_d  = inh_cnt_q;
        to_cnt_d   = to_cnt_q;
        ack_flag_d = ack_flag_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_err_d  = 1'b0;
        timeout_d  = 1'b0;

        if (in_xfer) begin
            to_cnt_d = to_cnt_q + ToW'(1);
        end

        case (state_q)
            StIdle: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                busy_d   = 1'b0;
                if (start) begin
                    state_d    = StInhibit;
                    busy_d     = 1'b1;
                    clk_oe_d   = 1'b1;
                    shreg_d    = tx_data;
                    parity_d   = ~^tx_data;
                    bitcnt_d   = 4'd0;
                    inh_cnt_d  = '0;
                    ack_flag_d = 1'b0;
                end
            end
            StInhibit: begin
                if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
                    state_d  = StReq;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    to_cnt_d = '0;
                end else begin
                    inh_cnt_d = inh_cnt_q + InhW'(1);
                end
            end
            StReq: begin
                if (fe) begin
                    dat_oe_d = ~shreg_q[0];
                    bitcnt_d = 4'd1;
                    state_d  = StData;
                end
            end
            StData: begin
                if (fe) begin
                    if (bitcnt_q == 4'd8) begin
                        dat_oe_d = ~parity_q;
                        state_d  = StParity;
                    end else begin
                        shreg_d  = {1'b0, shreg_q[7:1]};
                        dat_oe_d = ~shreg_q[1];
                        bitcnt_d = bitcnt_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (fe) begin
                    dat_oe_d = 1'b0;
                    state_d  = StStop;
                end
            end
            StStop: begin
                if (fe) begin
                    ack_flag_d = dat_s;
                    state_d    = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (clk_s && dat_s) begin
                    done_d    = 1'b1;
                    ack_err_d = ack_flag_q;
                    busy_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Timeout overrides any normal completion in the same cycle.
        if (in_xfer && (to_cnt_q == ToW'(TIMEOUT_CYCLES - 1))) begin
            clk_oe_d  = 1'b0;
            dat_oe_d  = 1'b0;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            ack_err_d = 1'b0;
            busy_d    = 1'b0;
            to_cnt_d  = '0;
            state_d   = StIdle;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= StIdle;
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            shreg_q    <= '0;
            parity_q   <= 1'b0;
            bitcnt_q   <= '0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            ack_flag_q <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            shreg_q    <= shreg_d;
            parity_q   <= parity_d;
            bitcnt_q   <= bitcnt_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            ack_flag_q <= ack_flag_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
            timeout_q  <= timeout_d;
        end
    end

    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign ack_err    = ack_err_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: models a PS/2 device on wired-AND pads and checks framing, ACK and
// timeout handling against hand-computed bit patterns.
module tb_ps2_host_tx;

    localparam int InhCycles = 10;
    localparam int ToCycles  = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       dev_clk;
    logic       dev_dat;
    logic       clk_pad;
    logic       dat_pad;
    logic       clk_oe;
    logic       dat_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    int n_checks = 0;
    int n_fails  = 0;
    int done_cnt = 0;
    int flag_errs = 0;
    int cyc = 0;
    int done_cyc = 0;
    int rel_cyc = 0;
    logic last_ack = 1'b0;
    logic last_to  = 1'b0;

    always #5 clk = ~clk;

    assign clk_pad = dev_clk & ~clk_oe;
    assign dat_pad = dev_dat & ~dat_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(InhCycles),
        .TIMEOUT_CYCLES(ToCycles)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .start     (start),
        .tx_data   (tx_data),
        .ps2_clk_in(clk_pad),
        .ps2_dat_in(dat_pad),
        .ps2_clk_oe(clk_oe),
        .ps2_dat_oe(dat_oe),
        .busy      (busy),
        .done      (done),
        .ack_err   (ack_err),
        .timeout   (timeout)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            last_ack = ack_err;
            last_to  = timeout;
        end else if (ack_err || timeout) begin
            flag_errs++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Device: 11 clock pulses (low 20 / high 20), samples host data on rising edges.
    task automatic device(input int npulses, input bit ack, input int rst_at, input int poke_at,
                          output logic [9:0] cap, output bit aborted);
        cap = '0;
        aborted = 1'b0;
        tick(20);
        for (int i = 1; i <= npulses; i++) begin
            if (i == 11 && ack) dev_dat = 1'b0;
            dev_clk = 1'b0;
            if (i == rst_at) begin
                tick(5);
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
                check("rst_clk_oe", 32'(clk_oe), 32'd0);
                check("rst_dat_oe", 32'(dat_oe), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                dev_clk = 1'b1;
                dev_dat = 1'b1;
                aborted = 1'b1;
                return;
            end
            tick(20);
            dev_clk = 1'b1;
            if (i <= 10) cap[i-1] = dat_pad;
            if (i == 11) dev_dat = 1'b1;
            if (i == poke_at) begin
                tx_data = 8'h55;
                start = 1'b1;
                tick(1);
                start = 1'b0;
                tick(19);
            end else begin
                tick(20);
            end
        end
    endtask

    task automatic run_tx(input logic [7:0] data, input int npulses, input bit ack,
                          input int rst_at, input int poke_at,
                          output logic [9:0] cap, output int dn, output bit aborted);
        int base;
        int hi;
        int w;
        base = done_cnt;
        tx_data = data;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        hi = 0;
        while (clk_oe && hi < 100) begin
            hi++;
            tick(1);
        end
        rel_cyc = cyc;
        check("inhibit_len", 32'(hi), 32'(InhCycles));
        check("start_bit_oe", 32'(dat_oe), 32'd1);
        device(npulses, ack, rst_at, poke_at, cap, aborted);
        if (aborted) begin
            tick(50);
            dn = done_cnt - base;
            return;
        end
        w = 0;
        while (done_cnt == base && w < ToCycles + 500) begin
            tick(1);
            w++;
        end
        tick(2);
        dn = done_cnt - base;
    endtask

    typedef struct packed {
        logic [7:0] data;
        logic [3:0] pulses;
        logic       ack;
        logic [9:0] bits;
        logic       exp_ack_err;
        logic       exp_to;
    } vec_t;

    vec_t       vecs[5];
    logic [9:0] cap;
    int         dn;
    bit         aborted;

    initial begin
        // bits = {stop, parity, data[7:0]} as seen by the device on rising edges
        vecs[0] = '{data: 8'hED, pulses: 4'd11, ack: 1'b1, bits: 10'h3ED, exp_ack_err: 1'b0, exp_to: 1'b0};
        vecs[1] = '{data: 8'h01, pulses: 4'd11, ack: 1'b1, bits: 10'h201, exp_ack_err: 1'b0, exp_to: 1'b0};
        vecs[2] = '{data: 8'hED, pulses: 4'd11, ack: 1'b0, bits: 10'h3ED, exp_ack_err: 1'b1, exp_to: 1'b0};
        vecs[3] = '{data: 8'hED, pulses: 4'd4,  ack: 1'b1, bits: 10'h000, exp_ack_err: 1'b0, exp_to: 1'b1};
        vecs[4] = '{data: 8'hFF, pulses: 4'd11, ack: 1'b1, bits: 10'h3FF, exp_ack_err: 1'b0, exp_to: 1'b0};

        reset = 1'b1;
        start = 1'b0;
        tx_data = 8'h00;
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        tick(3);
        check("reset_clk_oe", 32'(clk_oe), 32'd0);
        check("reset_dat_oe", 32'(dat_oe), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_ack_err", 32'(ack_err), 32'd0);
        check("reset_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        tick(5);

        for (int v = 0; v < 5; v++) begin
            run_tx(vecs[v].data, int'(vecs[v].pulses), vecs[v].ack, 0, 0, cap, dn, aborted);
            if (vecs[v].pulses == 4'd11) check($sformatf("bits_v%0d", v), 32'(cap), 32'(vecs[v].bits));
            check($sformatf("done_cnt_v%0d", v), 32'(dn), 32'd1);
            check($sformatf("ack_err_v%0d", v), 32'(last_ack), 32'(vecs[v].exp_ack_err));
            check($sformatf("timeout_v%0d", v), 32'(last_to), 32'(vecs[v].exp_to));
            check($sformatf("idle_clk_oe_v%0d", v), 32'(clk_oe), 32'd0);
            check($sformatf("idle_dat_oe_v%0d", v), 32'(dat_oe), 32'd0);
            check($sformatf("idle_busy_v%0d", v), 32'(busy), 32'd0);
            if (vecs[v].exp_to) check("timeout_latency", 32'(done_cyc - rel_cyc), 32'(ToCycles));
            tick(10);
        end

        // start pulsed mid-transaction must not replace the latched byte
        run_tx(8'hED, 11, 1'b1, 0, 3, cap, dn, aborted);
        check("busy_start_bits", 32'(cap), 32'h3ED);
        check("busy_start_done", 32'(dn), 32'd1);
        check("busy_start_ack", 32'(last_ack), 32'd0);
        tick(10);

        // reset after edge 5 aborts silently; the next byte goes out cleanly
        run_tx(8'hF4, 6, 1'b1, 6, 0, cap, dn, aborted);
        check("reset_aborted", 32'(aborted), 32'd1);
        check("reset_no_done", 32'(dn), 32'd0);
        run_tx(8'hF4, 11, 1'b1, 0, 0, cap, dn, aborted);
        check("f4_bits", 32'(cap), 32'h2F4);
        check("f4_done", 32'(dn), 32'd1);
        check("f4_ack_err", 32'(last_ack), 32'd0);
        check("f4_timeout", 32'(last_to), 32'd0);

        check("flags_only_with_done", 32'(flag_errs), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. It is the opposite direction of the existing keyboard receive path (keyboard_press_driver).
- Sends one command byte to the keyboard, for example 0xED (set LEDs) or 0xFF (reset), using open-drain control of PS2_CLK/PS2_DAT.
- Top level drives each pad low when its *_oe is 1 and leaves it Z otherwise. The receive path keeps reading the same pads.
- Handshake to game logic: start/busy/done with error flags.

Parameters:
- INHIBIT_CYCLES, 5000: cycles the host holds clock low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum cycles from clock release to bus-idle after ACK (15 ms at 50 MHz).

Ports:
- CLOCK_50, input, 1: system clock, 50 MHz.
- reset, input, 1: synchronous, active-high.
- start, input, 1: one-cycle request; sampled only in IDLE.
- tx_data, input, 8: byte to send; latched on accepted start.
- ps2_clk_in, input, 1: raw PS2_CLK pad level, asynchronous.
- ps2_dat_in, input, 1: raw PS2_DAT pad level, asynchronous.
- ps2_clk_oe, output, 1: 1 pulls PS2_CLK low.
- ps2_dat_oe, output, 1: 1 pulls PS2_DAT low.
- busy, output, 1: high from accepted start until done.
- done, output, 1: one-cycle pulse at end of every transaction, whether success or failure.
- ack_err, output, 1: valid with done; device did not ACK (data high at ACK edge).
- timeout, output, 1: valid with done; transaction exceeded TIMEOUT_CYCLES.

Behaviour:
- One clock (CLOCK_50); reset synchronous active-high.
- Reset values:
  - ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, ack_err=0, timeout=0.
  - State=IDLE, all counters 0.
- Reset mid-transaction releases both lines on the next edge and returns to IDLE with no done pulse.
- Input conditioning:
  - ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer.
  - A falling edge (fe) is previous synced clk=1 and current=0.
  - fe is ignored in IDLE and INHIBIT.
- Latched on accept: shreg <= tx_data, parity <= ~^tx_data (odd parity), bitcnt <= 0.
- IDLE: busy=0, both oe=0. start=1 moves to INHIBIT and sets busy=1 the same edge. start in any other state is ignored.
- INHIBIT:
  - clk_oe=1, dat_oe=0.
  - Inhibit counter runs INHIBIT_CYCLES cycles.
  - On expiry, go to REQ: dat_oe=1 (start bit 0) and clk_oe=0 on the same edge. Timeout counter is cleared.
- REQ:
  - Holds start bit, waiting for the device to clock.
  - On fe: dat_oe <= ~shreg[0], go to DATA, bitcnt=1.
- DATA:
  - On each fe, shift shreg right and drive the next bit, LSB first.
  - After bit7 has been presented (bitcnt=8), the next fe drives parity (dat_oe <= ~parity) and goes to PARITY.
- PARITY: on fe, dat_oe <= 0 (stop bit 1, line released), go to STOP.
- STOP: on fe, sample synced data: 0 means ACK ok, 1 sets the ack_err flag. Go to WAIT_IDLE.
- WAIT_IDLE: when synced clk=1 and data=1, pulse done=1 with ack_err per flag and busy=0 on the same cycle, then return to IDLE.
- Edge count: exactly 11 device falling edges per transaction after clock release.
  - Edges 1-8 present data bits.
  - Edge 9 presents parity.
  - Edge 10 releases for stop.
  - Edge 11 samples ACK.
- Timeout:
  - Counter increments every cycle in REQ, DATA, PARITY, STOP and WAIT_IDLE.
  - When it reaches TIMEOUT_CYCLES: both oe <= 0, done=1, timeout=1, ack_err=0, go to IDLE.
  - If timeout and the idle condition coincide on the same cycle, timeout wins.
- ack_err and timeout are zero whenever done=0.
- While IDLE, only the device drives the lines. The module never drives clock except during INHIBIT.
- Line encoding: ps2_dat_oe = 1 means the host is sending 0. Never drive high.

Test Plan:
- Setup: INHIBIT_CYCLES=10, TIMEOUT_CYCLES=2000. Bench models the device by generating 11 clock pulses (low 20 / high 20 cycles) after clock release.
- Send 0xED, device ACKs:
  - clk_oe high for 10 cycles, then dat_oe=1 start bit.
  - Bits sampled at device rising edges are 1,0,1,1,0,1,1,1, then parity 1, then stop 1.
  - done pulses once with ack_err=0, timeout=0; busy spans start to done.
- Send 0x01: parity bit 0 on line (dat_oe=1 during parity); otherwise same as above.
- Device holds data high at edge 11 (no ACK): done with ack_err=1, timeout=0; both oe=0 afterwards.
- Device stops after 4 clock pulses: at 2000 cycles after release, done=1, timeout=1, both oe=0, state IDLE. A subsequent start for 0xFF completes normally.
- start pulsed again while busy with 0x55: ignored; the transmitted byte remains the first one (0xED).
- reset asserted during DATA (after edge 5): next cycle both oe=0, busy=0, no done pulse. A new start then sends 0xF4 correctly.
